// File: rtl/tp_prio_arbiter_if.sv
// Signal bundle for tp_prio_arbiter: cbus, PHY and memory-side ports.
// slave is the arbiter's view; master is the requester/memory view.
interface tp_prio_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic          cbus_req;
  logic          cbus_cmd;
  logic [AW-1:0] cbus_addr;
  logic [DW-1:0] cbus_wrdata;
  logic          cbus_waccept;
  logic          cbus_raccept;
  logic          cbus_rresp;
  logic [DW-1:0] cbus_rdata;

  logic [AW-1:0] phy_wr_addr;
  logic [DW-1:0] phy_wr_data;
  logic          phy_wr_me_en;
  logic [DW-1:0] phy_wr_mask;
  logic [AW-1:0] phy_rd_addr;
  logic          phy_rd_me_en;
  logic          phy_wr_stall;
  logic          phy_rd_stall;

  logic [AW-1:0] wr_addr_out;
  logic [DW-1:0] wr_data_out;
  logic          wr_me_en_out;
  logic [DW-1:0] wr_mask_out;
  logic [AW-1:0] rd_addr_out;
  logic          rd_me_en_out;
  logic [DW-1:0] rd_data_in;

  modport slave (
    input  cbus_req, cbus_cmd, cbus_addr, cbus_wrdata,
    output cbus_waccept, cbus_raccept, cbus_rresp, cbus_rdata,
    input  phy_wr_addr, phy_wr_data, phy_wr_me_en, phy_wr_mask,
    input  phy_rd_addr, phy_rd_me_en,
    output phy_wr_stall, phy_rd_stall,
    output wr_addr_out, wr_data_out, wr_me_en_out, wr_mask_out,
    output rd_addr_out, rd_me_en_out,
    input  rd_data_in
  );

  modport master (
    output cbus_req, cbus_cmd, cbus_addr, cbus_wrdata,
    input  cbus_waccept, cbus_raccept, cbus_rresp, cbus_rdata,
    output phy_wr_addr, phy_wr_data, phy_wr_me_en, phy_wr_mask,
    output phy_rd_addr, phy_rd_me_en,
    input  phy_wr_stall, phy_rd_stall,
    input  wr_addr_out, wr_data_out, wr_me_en_out, wr_mask_out,
    input  rd_addr_out, rd_me_en_out,
    output rd_data_in
  );
endinterface

// File: rtl/tp_prio_arbiter.sv
// Two-port memory arbiter: PHY has priority, cbus gets per-port grants.
// Define TP_ARB_STARVE_GUARD_EN to enable the cbus starvation guard.
module tp_prio_arbiter #(
  parameter int DW         = 32,
  parameter int AW         = 32,
  parameter int RD_LAT     = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  tp_prio_arbiter_if.slave bus
);
  if (RD_LAT < 1 || RD_LAT > 8 ||
      STARVE_MAX < 1 || STARVE_MAX > 255) begin : g_cfg_bad
    $error("tp_prio_arbiter: parameter out of range");
  end

  logic              phy_w;
  logic              phy_r;
  logic              cbus_wr;
  logic              cbus_rd;
  logic              gnt_w;
  logic              gnt_r;
  logic              force_gnt;
  logic [RD_LAT-1:0] tag;
  logic              rresp;
  logic [DW-1:0]     rdata;

  // Everything that can move memory is held off while in reset.
  assign phy_w   = ~rst & bus.phy_wr_me_en;
  assign phy_r   = ~rst & bus.phy_rd_me_en;
  assign cbus_wr = ~rst & bus.cbus_req & ~bus.cbus_cmd;
  assign cbus_rd = ~rst & bus.cbus_req & bus.cbus_cmd;

  assign gnt_w = cbus_wr & (~phy_w | force_gnt);
  assign gnt_r = cbus_rd & (~phy_r | force_gnt);

`ifdef TP_ARB_STARVE_GUARD_EN
  localparam logic [7:0] CNT_MAX = 8'(STARVE_MAX);

  logic [7:0] cnt;

  assign force_gnt = (cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (~bus.cbus_req | gnt_w | gnt_r) begin
      cnt <= '0;
    end else if (!force_gnt) begin
      cnt <= cnt + 8'd1;
    end
  end
`else
  assign force_gnt = 1'b0;
`endif

  assign bus.wr_me_en_out = phy_w | gnt_w;
  assign bus.wr_addr_out  = gnt_w ? bus.cbus_addr   : bus.phy_wr_addr;
  assign bus.wr_data_out  = gnt_w ? bus.cbus_wrdata : bus.phy_wr_data;
  assign bus.wr_mask_out  = gnt_w ? {DW{1'b1}}      : bus.phy_wr_mask;

  assign bus.rd_me_en_out = phy_r | gnt_r;
  assign bus.rd_addr_out  = gnt_r ? bus.cbus_addr : bus.phy_rd_addr;

  assign bus.cbus_waccept = gnt_w;
  assign bus.cbus_raccept = gnt_r;
  assign bus.phy_wr_stall = gnt_w & phy_w;
  assign bus.phy_rd_stall = gnt_r & phy_r;

  // Tag marks which memory read slots belong to cbus.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag   <= '0;
      rresp <= 1'b0;
      rdata <= '0;
    end else begin
      tag[0] <= gnt_r;
      for (int i = 1; i < RD_LAT; i++) begin
        tag[i] <= tag[i-1];
      end
      rresp <= tag[RD_LAT-1];
      if (tag[RD_LAT-1]) begin
        rdata <= bus.rd_data_in;
      end
    end
  end

  assign bus.cbus_rresp = rresp;
  assign bus.cbus_rdata = rdata;
endmodule

// File: tb/tb_tp_prio_arbiter.sv
// Randomized + directed bench for tp_prio_arbiter against a cycle
// history model (grants from priority rules, returns from issue log).
module tb_tp_prio_arbiter;
  localparam int DW     = 32;
  localparam int AW     = 32;
  localparam int RD_LAT = 2;
  localparam int SM     = 4;
  localparam int NCYC   = 4096;
  localparam int VW     = 7 + 2*AW + 3*DW;
`ifdef TP_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tp_prio_arbiter_if #(.DW(DW), .AW(AW)) bus ();

  tp_prio_arbiter #(
    .DW(DW), .AW(AW), .RD_LAT(RD_LAT), .STARVE_MAX(SM)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  wire [VW-1:0] obs = {
    bus.cbus_waccept, bus.cbus_raccept, bus.cbus_rresp,
    bus.phy_wr_stall, bus.phy_rd_stall,
    bus.wr_me_en_out, bus.rd_me_en_out,
    bus.wr_addr_out, bus.wr_data_out, bus.wr_mask_out,
    bus.rd_addr_out, bus.cbus_rdata};

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int waited = 0;
  bit            rst_h [NCYC];
  bit            rdg   [NCYC];
  logic [DW-1:0] rdd   [NCYC];
  logic [DW-1:0] last_rdata = '0;
  bit            e_gw, e_gr, e_pw, e_pr, e_resp;
  logic [DW-1:0] e_rdata;
  logic [VW-1:0] expv;

  task automatic set_idle();
    bus.cbus_req     = 1'b0;
    bus.cbus_cmd     = 1'b0;
    bus.cbus_addr    = '0;
    bus.cbus_wrdata  = '0;
    bus.phy_wr_addr  = '0;
    bus.phy_wr_data  = '0;
    bus.phy_wr_me_en = 1'b0;
    bus.phy_wr_mask  = '0;
    bus.phy_rd_addr  = '0;
    bus.phy_rd_me_en = 1'b0;
    bus.rd_data_in   = '0;
  endtask

  // Expected outputs for the current cycle from the rules and history.
  task automatic model_eval();
    bit fg, w, r, live, prev_rst;
    int n;
    #3;
    fg   = GUARD && (waited >= SM);
    e_pw = !rst && bus.phy_wr_me_en;
    e_pr = !rst && bus.phy_rd_me_en;
    w    = !rst && bus.cbus_req && !bus.cbus_cmd;
    r    = !rst && bus.cbus_req && bus.cbus_cmd;
    e_gw = w && (!e_pw || fg);
    e_gr = r && (!e_pr || fg);
    n    = cyc - RD_LAT - 1;
    live = (n >= 0) && rdg[n];
    for (int k = n; k < cyc; k++) begin
      if (k >= 0 && rst_h[k]) live = 1'b0;
    end
    e_resp   = live;
    prev_rst = (cyc == 0) || rst_h[cyc-1];
    if (live) e_rdata = rdd[cyc-1];
    else if (prev_rst) e_rdata = '0;
    else e_rdata = last_rdata;
    expv = {e_gw, e_gr, e_resp, e_gw && e_pw, e_gr && e_pr,
            e_pw || e_gw, e_pr || e_gr,
            e_gw ? bus.cbus_addr   : bus.phy_wr_addr,
            e_gw ? bus.cbus_wrdata : bus.phy_wr_data,
            e_gw ? {DW{1'b1}}      : bus.phy_wr_mask,
            e_gr ? bus.cbus_addr   : bus.phy_rd_addr,
            e_rdata};
  endtask

  task automatic model_adv();
    rst_h[cyc] = rst;
    rdg[cyc]   = e_gr;
    rdd[cyc]   = bus.rd_data_in;
    if (rst || !bus.cbus_req || e_gw || e_gr) waited = 0;
    else if (waited < SM) waited++;
    last_rdata = e_rdata;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.cbus_req     = 1'b1;
    bus.cbus_cmd     = 1'b0;
    bus.cbus_addr    = 32'h0000_0044;
    bus.phy_wr_me_en = 1'b1;
    bus.phy_wr_addr  = 32'h0000_0100;
    bus.phy_wr_mask  = 32'h0000_FFFF;
    bus.phy_rd_me_en = 1'b1;
    bus.phy_rd_addr  = 32'h0000_0200;
    for (int k = 0; k < 3; k++) begin
      model_eval();
      if (obs !== expv) begin
        errors++;
        $display("FAIL reset_vec c=%0d got=%h want=%h", cyc, obs, expv);
      end
      checks++;
      if (obs[VW-1 -: 7] !== 7'b0) begin
        errors++;
        $display("FAIL reset_ctl c=%0d got=%b want=0", cyc, obs[VW-1 -: 7]);
      end
      checks++;
      model_adv();
    end
    rst = 1'b0;
    bus.cbus_req = 1'b0;
    model_eval();
    if (obs !== expv) begin
      errors++;
      $display("FAIL release_vec c=%0d got=%h want=%h", cyc, obs, expv);
    end
    checks++;
    if (bus.wr_me_en_out !== 1'b1 || bus.rd_me_en_out !== 1'b1 ||
        bus.wr_addr_out !== 32'h0000_0100 ||
        bus.rd_addr_out !== 32'h0000_0200) begin
      errors++;
      $display("FAIL release_pass got=%b%b %h %h want=11 100 200",
               bus.wr_me_en_out, bus.rd_me_en_out,
               bus.wr_addr_out, bus.rd_addr_out);
    end
    checks++;
    model_adv();
    set_idle();
  endtask

  task automatic test_cbus_write();
    bus.cbus_req    = 1'b1;
    bus.cbus_cmd    = 1'b0;
    bus.cbus_addr   = 32'h0000_0010;
    bus.cbus_wrdata = 32'hA5A5_A5A5;
    bus.phy_wr_mask = 32'h0000_000F;
    model_eval();
    if (obs !== expv) begin
      errors++;
      $display("FAIL cwr_vec c=%0d got=%h want=%h", cyc, obs, expv);
    end
    checks++;
    if (bus.cbus_waccept !== 1'b1 || bus.wr_me_en_out !== 1'b1 ||
        bus.wr_mask_out !== 32'hFFFF_FFFF ||
        bus.wr_addr_out !== 32'h0000_0010 ||
        bus.wr_data_out !== 32'hA5A5_A5A5) begin
      errors++;
      $display("FAIL cwr_direct got=%b%b %h %h %h want=11 10 a5a5a5a5 ffffffff",
               bus.cbus_waccept, bus.wr_me_en_out, bus.wr_addr_out,
               bus.wr_data_out, bus.wr_mask_out);
    end
    checks++;
    model_adv();
    set_idle();
  endtask

  task automatic test_cbus_read();
    bus.phy_wr_me_en = 1'b1;
    bus.phy_wr_addr  = 32'h0000_0300;
    bus.cbus_req     = 1'b1;
    bus.cbus_cmd     = 1'b1;
    bus.cbus_addr    = 32'h0000_0020;
    model_eval();
    if (obs !== expv) begin
      errors++;
      $display("FAIL crd_vec c=%0d got=%h want=%h", cyc, obs, expv);
    end
    checks++;
    if (bus.cbus_raccept !== 1'b1 || bus.rd_me_en_out !== 1'b1 ||
        bus.rd_addr_out !== 32'h0000_0020 ||
        bus.wr_me_en_out !== 1'b1 || bus.phy_wr_stall !== 1'b0) begin
      errors++;
      $display("FAIL crd_issue got=%b%b %h %b%b want=11 20 10",
               bus.cbus_raccept, bus.rd_me_en_out, bus.rd_addr_out,
               bus.wr_me_en_out, bus.phy_wr_stall);
    end
    checks++;
    model_adv();
    bus.cbus_req = 1'b0;
    for (int k = 1; k <= RD_LAT + 1; k++) begin
      bus.rd_data_in = (k == RD_LAT) ? 32'hDEAD_0001 : 32'($urandom);
      model_eval();
      if (obs !== expv) begin
        errors++;
        $display("FAIL crd_wait c=%0d got=%h want=%h", cyc, obs, expv);
      end
      checks++;
      if (k == RD_LAT + 1 &&
          (bus.cbus_rresp !== 1'b1 || bus.cbus_rdata !== 32'hDEAD_0001)) begin
        errors++;
        $display("FAIL crd_return got=%b %h want=1 dead0001",
                 bus.cbus_rresp, bus.cbus_rdata);
      end
      checks++;
      model_adv();
    end
    set_idle();
  endtask

  task automatic test_starvation();
    bit want;
    model_eval();
    model_adv();
    bus.phy_wr_me_en = 1'b1;
    bus.phy_wr_addr  = 32'h0000_0500;
    bus.cbus_req     = 1'b1;
    bus.cbus_cmd     = 1'b0;
    bus.cbus_addr    = 32'h0000_0600;
    for (int k = 0; k <= SM + 3; k++) begin
      model_eval();
      if (obs !== expv) begin
        errors++;
        $display("FAIL starve_vec c=%0d got=%h want=%h", cyc, obs, expv);
      end
      checks++;
`ifdef TP_ARB_STARVE_GUARD_EN
      want = (k == SM) || (k == 2*SM + 1);
`else
      want = 1'b0;
`endif
      if (bus.cbus_waccept !== want || bus.phy_wr_stall !== want ||
          bus.wr_me_en_out !== 1'b1) begin
        errors++;
        $display("FAIL starve_k%0d got=%b%b%b want=%b%b1", k,
                 bus.cbus_waccept, bus.phy_wr_stall, bus.wr_me_en_out,
                 want, want);
      end
      checks++;
      if (bus.cbus_waccept === 1'b1) bus.cbus_addr = bus.cbus_addr + 32'd4;
      model_adv();
    end
    set_idle();
  endtask

  task automatic test_reset_flush();
    model_eval();
    model_adv();
    // Two reads issue; the third attempt lands in the reset cycle.
    bus.cbus_req = 1'b1;
    bus.cbus_cmd = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rst = (k == 2);
      bus.cbus_addr = 32'h0000_0700 + 32'(k);
      model_eval();
      if (obs !== expv) begin
        errors++;
        $display("FAIL flush_issue c=%0d got=%h want=%h", cyc, obs, expv);
      end
      checks++;
      model_adv();
    end
    rst = 1'b0;
    bus.cbus_req = 1'b0;
    for (int k = 0; k < RD_LAT + 3; k++) begin
      bus.rd_data_in = 32'($urandom);
      model_eval();
      if (bus.cbus_rresp !== 1'b0 || bus.cbus_rdata !== 32'h0) begin
        errors++;
        $display("FAIL flush_k%0d got=%b %h want=0 0", k,
                 bus.cbus_rresp, bus.cbus_rdata);
      end
      checks++;
      model_adv();
    end
    set_idle();
  endtask

  task automatic test_random();
    bit acc = 1'b1;
    bit wst = 1'b0;
    bit rstl = 1'b0;
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(0, 49) == 0);
      if (!bus.cbus_req || acc) begin
        bus.cbus_req    = ($urandom_range(0, 2) != 0);
        bus.cbus_cmd    = 1'($urandom);
        bus.cbus_addr   = 32'($urandom);
        bus.cbus_wrdata = 32'($urandom);
      end
      if (!wst) begin
        bus.phy_wr_me_en = 1'($urandom);
        bus.phy_wr_addr  = 32'($urandom);
        bus.phy_wr_data  = 32'($urandom);
        bus.phy_wr_mask  = 32'($urandom);
      end
      if (!rstl) begin
        bus.phy_rd_me_en = 1'($urandom);
        bus.phy_rd_addr  = 32'($urandom);
      end
      bus.rd_data_in = 32'($urandom);
      model_eval();
      if (obs !== expv) begin
        errors++;
        $display("FAIL random c=%0d got=%h want=%h", cyc, obs, expv);
      end
      checks++;
      acc  = e_gw || e_gr;
      wst  = e_gw && e_pw;
      rstl = e_gr && e_pr;
      model_adv();
    end
    rst = 1'b0;
    set_idle();
  endtask

  initial begin
    set_idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_cbus_write();
    test_cbus_read();
    test_starvation();
    test_reset_flush();
    test_random();
    test_cbus_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
